// File: rtl/fxp_pkg.sv
// fxp_pkg: shared types, width derivation and channel word select for the operand mux
package fxp_pkg;
    localparam int INT_LENGTH_D  = 5;
    localparam int FRAC_LENGTH_D = 12;
    localparam int MAX_W         = 64;
    localparam int MAX_IN        = 64;
    localparam int IW            = 7;

    typedef enum logic {IDLE, SWEEP} state_t;
    typedef logic [MAX_W-1:0] word_t;

    function automatic int fxp_w(input int int_len, input int frac_len);
        return int_len + frac_len;
    endfunction

    function automatic word_t word(input word_t ch [MAX_IN], input logic [IW-1:0] n, input logic [IW-1:0] k);
        return (k < n) ? ch[k[IW-2:0]] : '0;
    endfunction
endpackage

// File: rtl/fxp_mux_seq_out_reg_slice.sv
// out_reg_slice: valid/ready output register holding the payload stable under backpressure
module out_reg_slice #(
    parameter int P = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [P-1:0] d,
    input  logic         out_ready,
    output logic [P-1:0] q,
    output logic         out_valid,
    output logic         can_load
);
    assign can_load = !out_valid || out_ready;

    // capture on load, drop valid once the held beat has been accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            q         <= d;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fxp_mux_seq.sv
// fxp_mux_seq: N-input fixed-point operand mux with direct and sweep modes, registered output
module fxp_mux_seq
    import fxp_pkg::*;
#(
    parameter int INT_LENGTH  = INT_LENGTH_D,
    parameter int FRAC_LENGTH = FRAC_LENGTH_D,
    parameter int NUM_IN      = 4,
    localparam int W          = fxp_w(INT_LENGTH, FRAC_LENGTH),
    localparam int SEL_W      = $clog2(NUM_IN),
    localparam int LEN_W      = $clog2(NUM_IN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                in_valid,
    input  logic                start,
    input  logic [LEN_W-1:0]    sweep_len,
    input  logic [NUM_IN*W-1:0] in_bus,
    input  logic                out_ready,
    output logic [W-1:0]        out_data,
    output logic                out_valid,
    output logic [SEL_W-1:0]    out_idx,
    output logic                out_last,
    output logic                busy
);
    localparam int P = W + SEL_W + 1;

    state_t            state, state_n;
    logic [LEN_W-1:0]  cnt, cnt_n, len, len_n, len_eff;
    logic              can_load, ld_direct, ld_start, ld_sweep, at_end, last_n;
    logic [IW-1:0]     ksel;
    logic [SEL_W-1:0]  idx_n;
    word_t             ch [MAX_IN];
    word_t             wsel;
    logic              unused_hi;

    for (genvar k = 0; k < MAX_IN; k++) begin : g_ch
        if (k < NUM_IN) begin : g_in
            assign ch[k] = word_t'(in_bus[k*W +: W]);
        end else begin : g_z
            assign ch[k] = '0;
        end
    end

    assign len_eff   = (sweep_len == '0 || sweep_len > LEN_W'(NUM_IN)) ? LEN_W'(NUM_IN) : sweep_len;
    assign ld_direct = state == IDLE && !mode && in_valid && can_load;
    assign ld_start  = state == IDLE && mode && start && can_load;
    assign ld_sweep  = state == SWEEP && can_load;
    assign at_end    = cnt == len - LEN_W'(1);
    assign busy      = state == SWEEP;
    assign ksel      = ld_direct ? IW'(sel) : ld_sweep ? IW'(cnt) : '0;
    assign idx_n     = ld_direct ? sel : ld_sweep ? cnt[SEL_W-1:0] : '0;
    assign last_n    = ld_direct ? 1'b1 : ld_start ? (len_eff == LEN_W'(1)) : at_end;
    assign wsel      = word(ch, IW'(NUM_IN), ksel);
    assign unused_hi = ^wsel;

    // sweep sequencing: state, next channel and the length latched at start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            len   <= len_n;
        end
    end

    // next-state: a start begins the sweep at channel 0, each accepted slot advances it
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        if (ld_start) begin
            cnt_n   = LEN_W'(1);
            len_n   = len_eff;
            state_n = (len_eff > LEN_W'(1)) ? SWEEP : IDLE;
        end
        if (ld_sweep) begin
            cnt_n   = cnt + LEN_W'(1);
            state_n = at_end ? IDLE : SWEEP;
        end
    end

    out_reg_slice #(.P(P)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ld_direct || ld_start || ld_sweep),
        .d         ({wsel[W-1:0], idx_n, last_n}),
        .out_ready (out_ready),
        .q         ({out_data, out_idx, out_last}),
        .out_valid (out_valid),
        .can_load  (can_load)
    );
endmodule

// File: tb/tb_fxp_mux_seq.sv
// tb_fxp_mux_seq: directed checks of direct, sweep, backpressure, edge lengths and reset
module tb_fxp_mux_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mode, in_valid, start, out_ready;
    logic [1:0]  sel;
    logic [2:0]  sweep_len;
    logic [67:0] in_bus;
    logic [16:0] out_data;
    logic        out_valid, out_last, busy;
    logic [1:0]  out_idx;

    logic        mode3, in_valid3, start3, out_ready3;
    logic [1:0]  sel3, sweep_len3;
    logic [50:0] in_bus3;
    logic [16:0] out_data3;
    logic        out_valid3, out_last3, busy3;
    logic [1:0]  out_idx3;

    logic [16:0] ch4 [4] = '{17'h00011, 17'h10022, 17'h01800, 17'h1F0F0};
    logic [16:0] ch3 [4] = '{17'h12345, 17'h0ABCD, 17'h1FFFF, 17'h00000};

    int checks = 0;
    int failures = 0;

    fxp_mux_seq #(.NUM_IN(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
        .start(start), .sweep_len(sweep_len), .in_bus(in_bus), .out_ready(out_ready),
        .out_data(out_data), .out_valid(out_valid), .out_idx(out_idx),
        .out_last(out_last), .busy(busy)
    );

    fxp_mux_seq #(.NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_valid(in_valid3),
        .start(start3), .sweep_len(sweep_len3), .in_bus(in_bus3), .out_ready(out_ready3),
        .out_data(out_data3), .out_valid(out_valid3), .out_idx(out_idx3),
        .out_last(out_last3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input int idx, input logic last, input logic bsy);
        chk({tag, " valid"}, 32'(out_valid), 1);
        chk({tag, " idx"}, 32'(out_idx), 32'(idx));
        chk({tag, " data"}, 32'(out_data), 32'(ch4[idx]));
        chk({tag, " last"}, 32'(out_last), 32'(last));
        chk({tag, " busy"}, 32'(busy), 32'(bsy));
    endtask

    initial begin
        mode = 0; in_valid = 0; start = 0; out_ready = 1; sel = 0; sweep_len = 4;
        in_bus = {ch4[3], ch4[2], ch4[1], ch4[0]};
        mode3 = 0; in_valid3 = 0; start3 = 0; out_ready3 = 1; sel3 = 0; sweep_len3 = 0;
        in_bus3 = {ch3[2], ch3[1], ch3[0]};
        #3;
        chk("reset valid", 32'(out_valid), 0);
        chk("reset data", 32'(out_data), 0);
        chk("reset idx", 32'(out_idx), 0);
        chk("reset last", 32'(out_last), 0);
        chk("reset busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        for (int s = 0; s < 4; s++) begin
            sel3 = 2'(s);
            in_valid3 = 1;
            tick();
            chk("legacy valid", 32'(out_valid3), 1);
            chk("legacy data", 32'(out_data3), 32'(ch3[s]));
            chk("legacy idx", 32'(out_idx3), 32'(s));
            chk("legacy last", 32'(out_last3), 1);
        end
        in_valid3 = 0;
        tick();
        chk("legacy drain", 32'(out_valid3), 0);

        sel = 2; in_valid = 1;
        tick();
        in_valid = 0;
        beat("direct", 2, 1, 0);
        tick();
        chk("direct drain", 32'(out_valid), 0);

        mode = 1; sweep_len = 4; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 4; i++) begin
            beat("sweep", i, i == 3, i < 3);
            start = (i == 1);
            tick();
        end
        start = 0;
        chk("sweep end valid", 32'(out_valid), 0);
        chk("sweep end busy", 32'(busy), 0);

        start = 1;
        tick();
        start = 0;
        beat("bp c1", 0, 0, 1);
        tick();
        beat("bp c2", 1, 0, 1);
        out_ready = 0;
        tick();
        beat("bp c3", 1, 0, 1);
        tick();
        beat("bp c4", 1, 0, 1);
        out_ready = 1;
        tick();
        beat("bp c5", 2, 0, 1);
        tick();
        beat("bp c6", 3, 1, 0);
        tick();
        chk("bp drain", 32'(out_valid), 0);

        for (int l = 0; l < 2; l++) begin
            sweep_len = (l == 0) ? 3'd0 : 3'd5;
            start = 1;
            tick();
            start = 0;
            for (int i = 0; i < 4; i++) begin
                beat(l == 0 ? "len0" : "len5", i, i == 3, i < 3);
                tick();
            end
            chk("clamp drain", 32'(out_valid), 0);
        end

        sweep_len = 1; start = 1;
        tick();
        start = 0;
        beat("len1", 0, 1, 0);
        tick();
        chk("len1 drain", 32'(out_valid), 0);
        chk("len1 busy", 32'(busy), 0);

        mode = 0; start = 1;
        tick();
        start = 0;
        chk("start in direct", 32'(out_valid), 0);

        mode = 1; in_valid = 1;
        tick();
        in_valid = 0;
        chk("in_valid in sweep", 32'(out_valid), 0);

        sweep_len = 4; start = 1;
        tick();
        start = 0;
        tick();
        beat("pre-reset", 1, 0, 1);
        #2;
        rst_n = 0;
        #1;
        chk("mid reset valid", 32'(out_valid), 0);
        chk("mid reset data", 32'(out_data), 0);
        chk("mid reset idx", 32'(out_idx), 0);
        chk("mid reset busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1;
        start = 1;
        tick();
        start = 0;
        beat("restart", 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
